// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, DBIT data bits LSB first, one parity bit, stop.
// Paced by a 16x oversampling s_tick strobe; tx, tx_busy and tx_done_tick are registered.
module uart_tx_parity #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int            NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
    localparam logic [4:0]    BIT_LAST  = 5'd15;
    localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);
    localparam logic          PODD      = (PARITY_ODD != 0);

    state_t          state_q, state_d;
    logic [4:0]      s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] sh_q, sh_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_d     = n_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Still IDLE during the done pulse, but a request there is held off one cycle.
                if (tx_start && !done_q) begin
                    sh_d    = din;
                    par_d   = (^din) ^ PODD;
                    s_cnt_d = '0;
                    n_d     = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        n_d     = '0;
                        tx_d    = sh_q[0];
                        state_d = DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        if (n_q == N_LAST) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            sh_d = sh_q >> 1;
                            tx_d = sh_q[1];
                            n_d  = n_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        s_cnt_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx_parity.sv
// Bench for uart_tx_parity: even/SB16, odd/SB16 and even/SB32 instances share clk, reset and s_tick.
module tb_uart_tx_parity;
    logic       clk = 1'b0;
    logic       rst;
    logic       tie1;
    logic       bclr;
    int         m_div;
    int         bcnt;
    logic       gen_tick;
    logic       s_tick;
    logic [2:0] tx_start_v;
    logic [7:0] din_a [3];
    logic [2:0] tx_w, busy_w, done_w;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    // Baud strobe model: one tick every m_div clocks, phase cleared on request.
    always @(posedge clk) begin
        if (bclr || bcnt >= m_div - 1) bcnt <= 0;
        else                           bcnt <= bcnt + 1;
    end
    assign gen_tick = (bcnt == m_div - 1);
    assign s_tick   = tie1 ? 1'b1 : gen_tick;

    uart_tx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) u_even (
        .clk(clk), .reset(rst), .s_tick(s_tick), .tx_start(tx_start_v[0]), .din(din_a[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]));
    uart_tx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1)) u_odd (
        .clk(clk), .reset(rst), .s_tick(s_tick), .tx_start(tx_start_v[1]), .din(din_a[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]));
    uart_tx_parity #(.DBIT(8), .SB_TICK(32), .PARITY_ODD(0)) u_sb32 (
        .clk(clk), .reset(rst), .s_tick(s_tick), .tx_start(tx_start_v[2]), .din(din_a[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One frame: rp >= 0 re-pulses tx_start with din=FF at that many edges after acceptance.
    task automatic frame(input int idx, input logic [7:0] d, input logic p, input int sb,
                         input int m, input int rp, input string nm);
        logic [10:0] e;
        int          donep, bbad, gl;
        logic        ptx, ptick;
        e     = {1'b1, p, d, 1'b0};
        donep = 160 * m + sb * m;
        bbad  = 0;
        gl    = 0;
        @(negedge clk);
        din_a[idx] = d; tx_start_v[idx] = 1'b1; bclr = 1'b1;
        @(negedge clk);
        tx_start_v[idx] = 1'b0; bclr = 1'b0;
        chk({nm, "_start_fall"}, {31'd0, tx_w[idx]}, 32'd0);
        ptx   = tx_w[idx];
        ptick = s_tick;
        for (int pos = 0; pos <= donep + 40; pos++) begin
            if (pos > 0) begin
                if (tx_w[idx] !== ptx && !ptick) gl++;
                ptx   = tx_w[idx];
                ptick = s_tick;
            end
            if (pos == rp) begin
                din_a[idx] = 8'hFF; tx_start_v[idx] = 1'b1;
            end
            if (rp >= 0 && pos == rp + 1) begin
                din_a[idx] = 8'h00; tx_start_v[idx] = 1'b0;
            end
            for (int k = 0; k < 11; k++)
                if (pos == 16 * k * m + 8 * m)
                    chk($sformatf("%s_bit%0d", nm, k), {31'd0, tx_w[idx]}, {31'd0, e[k]});
            if (pos < donep && busy_w[idx] !== 1'b1) bbad++;
            if (pos == donep - 1) chk({nm, "_done_early"}, {31'd0, done_w[idx]}, 32'd0);
            if (pos == donep) begin
                chk({nm, "_done"}, {31'd0, done_w[idx]}, 32'd1);
                chk({nm, "_busy_drop"}, {31'd0, busy_w[idx]}, 32'd0);
            end
            if (pos > donep && (done_w[idx] !== 1'b0 || busy_w[idx] !== 1'b0 || tx_w[idx] !== 1'b1))
                bbad++;
            @(negedge clk);
        end
        chk({nm, "_busy_idle"}, bbad, 0);
        chk({nm, "_tx_between_ticks"}, gl, 0);
    endtask

    typedef struct {
        int         idx;
        logic [7:0] din;
        logic       par;
        int         sb;
    } vec_t;
    vec_t tbl [8];

    initial begin
        int   cnt;
        logic [10:0] e;
        tbl[0] = '{0, 8'hA5, 1'b0, 16};
        tbl[1] = '{1, 8'h07, 1'b0, 16};
        tbl[2] = '{0, 8'h07, 1'b1, 16};
        tbl[3] = '{1, 8'h00, 1'b1, 16};
        tbl[4] = '{0, 8'h00, 1'b0, 16};
        tbl[5] = '{0, 8'hFF, 1'b0, 16};
        tbl[6] = '{1, 8'h55, 1'b1, 16};
        tbl[7] = '{2, 8'h3C, 1'b0, 32};

        rst = 1'b1; tie1 = 1'b1; bclr = 1'b0; m_div = 1; tx_start_v = '0;
        for (int i = 0; i < 3; i++) din_a[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", {29'd0, tx_w}, 32'd7);
        chk("reset_busy", {29'd0, busy_w}, 32'd0);
        chk("reset_done", {29'd0, done_w}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            frame(tbl[i].idx, tbl[i].din, tbl[i].par, tbl[i].sb, 1, -1, $sformatf("vec%0d", i));

        tie1 = 1'b0; m_div = 163;
        frame(0, 8'h3C, 1'b0, 16, 163, -1, "baud163");
        tie1 = 1'b1; m_div = 1;

        frame(0, 8'h55, 1'b0, 16, 1, 60, "repulse");

        // tx_start held high across the done pulse: restart exactly two clocks later.
        e = {1'b1, 1'b0, 8'h5A, 1'b0};
        @(negedge clk);
        din_a[0] = 8'h5A; tx_start_v[0] = 1'b1;
        @(negedge clk);
        for (int pos = 0; pos <= 178; pos++) begin
            for (int k = 0; k < 11; k++)
                if (pos == 16 * k + 8) chk($sformatf("held_bit%0d", k), {31'd0, tx_w[0]}, {31'd0, e[k]});
            if (pos == 176) chk("held_done", {31'd0, done_w[0]}, 32'd1);
            if (pos == 177) chk("held_gap_tx", {31'd0, tx_w[0]}, 32'd1);
            if (pos == 178) begin
                chk("held_restart_tx", {31'd0, tx_w[0]}, 32'd0);
                chk("held_restart_busy", {31'd0, busy_w[0]}, 32'd1);
            end
            if (pos < 178) @(negedge clk);
        end
        tx_start_v[0] = 1'b0;
        repeat (176) @(negedge clk);
        chk("held_second_done", {31'd0, done_w[0]}, 32'd1);
        repeat (3) @(negedge clk);

        // Reset in the middle of the parity bit abandons the frame at once.
        din_a[0] = 8'hC3; tx_start_v[0] = 1'b1;
        @(negedge clk);
        tx_start_v[0] = 1'b0;
        repeat (150) @(negedge clk);
        chk("rst_pre_parity", {31'd0, tx_w[0]}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_tx", {31'd0, tx_w[0]}, 32'd1);
        chk("rst_async_busy", {31'd0, busy_w[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) cnt++;
        end
        chk("rst_no_done", cnt, 0);
        frame(0, 8'h81, 1'b0, 16, 1, -1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
